// File: rtl/piece_ref_ctrl.sv
// Reference-position controller for the falling Tetris piece: user moves, gravity,
// hard drop and lock sequencing, with wall clamping against the playfield parameters.
module piece_ref_ctrl #(
    parameter int unsigned ROWS      = 20,
    parameter int unsigned COLS      = 10,
    parameter int unsigned ROW_W     = 5,
    parameter int unsigned COL_W     = 4,
    parameter int unsigned SPAWN_ROW = 0,
    parameter int unsigned SPAWN_COL = 3,
    parameter int unsigned GRAV_W    = 6
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              spawn,
    input  logic              move_valid,
    output logic              move_ready,
    input  logic [2:0]        move,
    input  logic              tick,
    input  logic [GRAV_W-1:0] grav_period,
    input  logic              blk_left,
    input  logic              blk_right,
    input  logic              blk_down,
    output logic [ROW_W-1:0]  row_o,
    output logic [COL_W-1:0]  col_o,
    output logic              active,
    output logic              done,
    output logic              locked
);

    localparam logic [ROW_W-1:0] RowMax   = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] ColMax   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] RowSpawn = ROW_W'(SPAWN_ROW);
    localparam logic [COL_W-1:0] ColSpawn = COL_W'(SPAWN_COL);

    localparam logic [2:0] MvLeft  = 3'd1;
    localparam logic [2:0] MvRight = 3'd2;
    localparam logic [2:0] MvDown  = 3'd3;
    localparam logic [2:0] MvHard  = 3'd4;

    typedef enum logic [1:0] {StIdle, StActive, StDrop, StLock} state_e;

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [GRAV_W-1:0] cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              done_q, done_d;

    logic              accept;
    logic              soft_down;
    logic [GRAV_W:0]   cnt_inc;

    assign move_ready = (state_q == StActive);
    assign active     = (state_q == StActive) || (state_q == StDrop);
    assign locked     = (state_q == StLock);
    assign done       = done_q;
    assign row_o      = row_q;
    assign col_o      = col_q;

    assign accept  = move_valid && move_ready;
    assign cnt_inc = {1'b0, cnt_q} + {{GRAV_W{1'b0}}, 1'b1};

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        done_d    = 1'b0;
        soft_down = 1'b0;

        case (state_q)
            StIdle: begin
                if (spawn) begin
                    state_d = StActive;
                    row_d   = RowSpawn;
                    col_d   = ColSpawn;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            StActive: begin
                if (spawn) begin
                    row_d  = RowSpawn;
                    col_d  = ColSpawn;
                    cnt_d  = '0;
                    pend_d = 1'b0;
                end else begin
                    // User request has priority; a pending gravity drop waits for an idle cycle.
                    if (accept) begin
                        case (move)
                            MvLeft: begin
                                if (col_q != '0 && !blk_left) begin
                                    col_d  = col_q - 1'b1;
                                    done_d = 1'b1;
                                end
                            end
                            MvRight: begin
                                if (col_q < ColMax && !blk_right) begin
                                    col_d  = col_q + 1'b1;
                                    done_d = 1'b1;
                                end
                            end
                            MvDown: begin
                                soft_down = 1'b1;
                                if (blk_down || row_q == RowMax) begin
                                    state_d = StLock;
                                end else begin
                                    row_d  = row_q + 1'b1;
                                    done_d = 1'b1;
                                end
                            end
                            MvHard:  state_d = StDrop;
                            default: ;
                        endcase
                    end else if (pend_q) begin
                        pend_d = 1'b0;
                        if (blk_down || row_q == RowMax) begin
                            state_d = StLock;
                        end else begin
                            row_d  = row_q + 1'b1;
                            done_d = 1'b1;
                        end
                    end

                    // A soft drop restarts the gravity timer.
                    if (soft_down) begin
                        cnt_d  = '0;
                        pend_d = 1'b0;
                    end else if (tick && grav_period != '0) begin
                        if (cnt_inc >= {1'b0, grav_period}) begin
                            cnt_d  = '0;
                            pend_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc[GRAV_W-1:0];
                        end
                    end
                end
            end
            StDrop: begin
                if (spawn) begin
                    state_d = StActive;
                    row_d   = RowSpawn;
                    col_d   = ColSpawn;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else if (!blk_down && row_q < RowMax) begin
                    row_d  = row_q + 1'b1;
                    done_d = 1'b1;
                end else begin
                    state_d = StLock;
                end
            end
            StLock: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            row_q   <= RowSpawn;
            col_q   <= ColSpawn;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

endmodule
